// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the next-PC sequencer.
package pc_seq_pkg;
   localparam int XLEN       = 32;
   localparam int INSN_BYTES = 4;

   typedef enum logic [1:0] {BOOT, RUN, HOLD, REDIR} seq_state_t;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_JMP  = 2'd1;
   localparam logic [1:0] SRC_BR   = 2'd2;
   localparam logic [1:0] SRC_TRAP = 2'd3;

   // {flush_id_ex, flush_if_id}: jumps are decoded in ID, so only IF/ID holds a wrong-path slot
   function automatic logic [1:0] flush_of(input logic [1:0] src);
      return {src == SRC_BR || src == SRC_TRAP, src != SRC_NONE};
   endfunction

   function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
      return a & ~XLEN'(INSN_BYTES - 1);
   endfunction
endpackage

// File: rtl/pc_redirect_mux.sv
// pc_redirect_mux: priority select (trap > branch > jump) of redirect target, source and flushes.
// Trap input exists only when PC_SEQ_TRAP_EN is defined.
module pc_redirect_mux
   import pc_seq_pkg::*;
(
`ifdef PC_SEQ_TRAP_EN
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_vec,
`endif
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            jmp_valid,
   input  logic [XLEN-1:0] jmp_target,
   output logic [XLEN-1:0] target,
   output logic [1:0]      src,
   output logic            flush_if_id,
   output logic            flush_id_ex
);
   logic [XLEN-1:0] raw;

   always_comb begin
      src = br_taken ? SRC_BR : jmp_valid ? SRC_JMP : SRC_NONE;
      raw = br_taken ? br_target : jmp_target;
`ifdef PC_SEQ_TRAP_EN
      src = trap_req ? SRC_TRAP : src;
      raw = trap_req ? trap_vec : raw;
`endif
   end

   assign target = align(raw);
   assign {flush_id_ex, flush_if_id} = flush_of(src);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller sequencing boot, run, stall hold and redirect flushes.
// Define PC_SEQ_TRAP_EN to add the trap request/vector ports with top redirect priority.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VEC    = 32'h0000_0000,
   parameter int              BOOT_CYCLES  = 4,
   parameter int              FLUSH_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            jmp_valid,
   input  logic [XLEN-1:0] jmp_target,
`ifdef PC_SEQ_TRAP_EN
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_vec,
`endif
   output logic [XLEN-1:0] pc_nxt,
   output logic            pc_rst,
   output logic            fetch_en,
   output logic            flush_if_id,
   output logic            flush_id_ex,
   output logic [1:0]      redir_src
);
   localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

   seq_state_t      state;
   logic [3:0]      cnt;
   logic [1:0]      src_q;
   logic            active;
   logic            redir;
   logic [XLEN-1:0] tgt;
   logic [1:0]      src;
   logic            fl_if;
   logic            fl_ex;

   assign active = state == RUN || state == HOLD;
   assign redir  = src != SRC_NONE;

   // Branch/jump in REDIR come from squashed slots; only a trap may re-redirect there
   pc_redirect_mux u_mux (
`ifdef PC_SEQ_TRAP_EN
      .trap_req   (trap_req && (active || state == REDIR)),
      .trap_vec   (trap_vec),
`endif
      .br_taken   (br_taken && active),
      .br_target  (br_target),
      .jmp_valid  (jmp_valid && active),
      .jmp_target (jmp_target),
      .target     (tgt),
      .src        (src),
      .flush_if_id(fl_if),
      .flush_id_ex(fl_ex)
   );

   always_comb begin
      pc_rst    = !rst || (state == BOOT && cnt != BOOT_LAST);
      pc_nxt    = state == BOOT ? RESET_VEC : redir ? tgt : (active && stall) ? pc : pc + XLEN'(INSN_BYTES);
      fetch_en  = redir || state == REDIR || (active && !stall);
      {flush_id_ex, flush_if_id} = state == BOOT ? 2'b11 : redir ? {fl_ex, fl_if} :
                                   state == REDIR ? flush_of(src_q) : 2'b00;
      redir_src = redir ? src : state == REDIR ? src_q : SRC_NONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= BOOT;
         cnt   <= '0;
         src_q <= SRC_NONE;
      end else if (redir) begin
         state <= FLUSH_CYCLES > 1 ? REDIR : RUN;
         cnt   <= 4'd1;
         src_q <= src;
      end else begin
         case (state)
            BOOT: begin
               cnt   <= cnt + 4'd1;
               state <= cnt == BOOT_LAST ? RUN : BOOT;
            end
            REDIR: begin
               cnt   <= cnt + 4'd1;
               state <= cnt == FLUSH_LAST ? RUN : REDIR;
            end
            default: state <= stall ? HOLD : RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table plus scoreboard for pc_sequencer (BOOT_CYCLES=4, FLUSH_CYCLES=2).
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp_valid;
   logic [31:0] jmp_target;
   logic        trap_req;
   logic [31:0] trap_vec;
   logic [31:0] pc_nxt;
   logic        pc_rst;
   logic        fetch_en;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic [1:0]  redir_src;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        r;
      logic [31:0] p;
      logic        st;
      logic        br;
      logic [31:0] bt;
      logic        jv;
      logic [31:0] jt;
      logic        tr;
      logic [31:0] tv;
      logic [37:0] x;
   } vec_t;

   vec_t        tbl[$];
   logic [37:0] sb[$];

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_VEC(32'h0), .BOOT_CYCLES(4), .FLUSH_CYCLES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp_valid  (jmp_valid),
      .jmp_target (jmp_target),
`ifdef PC_SEQ_TRAP_EN
      .trap_req   (trap_req),
      .trap_vec   (trap_vec),
`endif
      .pc_nxt     (pc_nxt),
      .pc_rst     (pc_rst),
      .fetch_en   (fetch_en),
      .flush_if_id(flush_if_id),
      .flush_id_ex(flush_id_ex),
      .redir_src  (redir_src)
   );

   function automatic logic [37:0] e(input logic [31:0] n, input logic r, input logic f,
                                     input logic fi, input logic fx, input logic [1:0] s);
      return {n, r, f, fi, fx, s};
   endfunction

   function automatic vec_t v(input logic r, input logic [31:0] p, input logic st,
                              input logic br, input logic [31:0] bt, input logic jv,
                              input logic [31:0] jt, input logic tr, input logic [31:0] tv,
                              input logic [37:0] x);
      vec_t t;
      t.r = r; t.p = p; t.st = st; t.br = br; t.bt = bt;
      t.jv = jv; t.jt = jt; t.tr = tr; t.tv = tv; t.x = x;
      return t;
   endfunction

   task automatic check(input string name);
      logic [37:0] got;
      logic [37:0] want;
      got = {pc_nxt, pc_rst, fetch_en, flush_if_id, flush_id_ex, redir_src};
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s scoreboard empty, got=%h", name, got);
      end else begin
         want = sb.pop_front();
         if (got !== want) begin
            bad++;
            $display("FAIL %s got pc_nxt=%h rst=%b fe=%b fif=%b fie=%b src=%0d want pc_nxt=%h rst=%b fe=%b fif=%b fie=%b src=%0d",
                     name, got[37:6], got[5], got[4], got[3], got[2], got[1:0],
                     want[37:6], want[5], want[4], want[3], want[2], want[1:0]);
         end
      end
   endtask

   task automatic apply(input vec_t t, input string name);
      rst = t.r; pc = t.p; stall = t.st; br_taken = t.br; br_target = t.bt;
      jmp_valid = t.jv; jmp_target = t.jt; trap_req = t.tr; trap_vec = t.tv;
      sb.push_back(t.x);
      @(negedge clk);
      check(name);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [31:0] p;
      logic [31:0] nx;
      logic        s;
      logic [6:0]  pat;
      // reset and boot
      tbl.push_back(v(0, 32'h0,  0, 0, 0, 0, 0, 0, 0, e(32'h0, 1, 0, 1, 1, 0)));
      tbl.push_back(v(1, 32'h0,  0, 0, 0, 0, 0, 0, 0, e(32'h0, 1, 0, 1, 1, 0)));
      tbl.push_back(v(1, 32'h0,  0, 0, 0, 0, 0, 0, 0, e(32'h0, 1, 0, 1, 1, 0)));
      tbl.push_back(v(1, 32'h0,  0, 0, 0, 0, 0, 0, 0, e(32'h0, 1, 0, 1, 1, 0)));
      tbl.push_back(v(1, 32'h0,  0, 0, 0, 0, 0, 0, 0, e(32'h0, 0, 0, 1, 1, 0)));
      tbl.push_back(v(1, 32'h0,  0, 0, 0, 0, 0, 0, 0, e(32'h4, 0, 1, 0, 0, 0)));
      tbl.push_back(v(1, 32'h4,  0, 0, 0, 0, 0, 0, 0, e(32'h8, 0, 1, 0, 0, 0)));
      tbl.push_back(v(1, 32'h8,  0, 0, 0, 0, 0, 0, 0, e(32'hC, 0, 1, 0, 0, 0)));
      // branch beats jump, then REDIR ignores branch/jump/stall
      tbl.push_back(v(1, 32'h10, 0, 1, 32'h83, 1, 32'h200, 0, 0, e(32'h80, 0, 1, 1, 1, 2)));
      tbl.push_back(v(1, 32'h80, 1, 1, 32'h300, 1, 32'h200, 0, 0, e(32'h84, 0, 1, 1, 1, 2)));
      tbl.push_back(v(1, 32'h84, 0, 0, 0, 0, 0, 0, 0, e(32'h88, 0, 1, 0, 0, 0)));
      // three stall cycles at 0x40
      tbl.push_back(v(1, 32'h40, 1, 0, 0, 0, 0, 0, 0, e(32'h40, 0, 0, 0, 0, 0)));
      tbl.push_back(v(1, 32'h40, 1, 0, 0, 0, 0, 0, 0, e(32'h40, 0, 0, 0, 0, 0)));
      tbl.push_back(v(1, 32'h40, 1, 0, 0, 0, 0, 0, 0, e(32'h40, 0, 0, 0, 0, 0)));
      tbl.push_back(v(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, e(32'h44, 0, 1, 0, 0, 0)));
      tbl.push_back(v(1, 32'h44, 0, 0, 0, 0, 0, 0, 0, e(32'h48, 0, 1, 0, 0, 0)));
      // jump while stalled in HOLD
      tbl.push_back(v(1, 32'h48, 1, 0, 0, 0, 0, 0, 0, e(32'h48, 0, 0, 0, 0, 0)));
      tbl.push_back(v(1, 32'h48, 1, 0, 0, 1, 32'h203, 0, 0, e(32'h200, 0, 1, 1, 0, 1)));
      tbl.push_back(v(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, e(32'h204, 0, 1, 1, 0, 1)));
      // wrap
      tbl.push_back(v(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, e(32'h0, 0, 1, 0, 0, 0)));
      // reset dropped in REDIR, then reboot with branch ignored
      tbl.push_back(v(1, 32'h100, 0, 0, 0, 1, 32'h401, 0, 0, e(32'h400, 0, 1, 1, 0, 1)));
      tbl.push_back(v(0, 32'h400, 0, 0, 0, 0, 0, 0, 0, e(32'h0, 1, 0, 1, 1, 0)));
      tbl.push_back(v(1, 32'h0,  0, 0, 0, 0, 0, 0, 0, e(32'h0, 1, 0, 1, 1, 0)));
      tbl.push_back(v(1, 32'h0,  0, 1, 32'h80, 0, 0, 0, 0, e(32'h0, 1, 0, 1, 1, 0)));
      tbl.push_back(v(1, 32'h0,  0, 0, 0, 0, 0, 0, 0, e(32'h0, 1, 0, 1, 1, 0)));
      tbl.push_back(v(1, 32'h0,  0, 0, 0, 0, 0, 0, 0, e(32'h0, 0, 0, 1, 1, 0)));
      tbl.push_back(v(1, 32'h0,  0, 0, 0, 0, 0, 0, 0, e(32'h4, 0, 1, 0, 0, 0)));
      // branch wins over stall
      tbl.push_back(v(1, 32'h4,  1, 1, 32'h1002, 0, 0, 0, 0, e(32'h1000, 0, 1, 1, 1, 2)));
      tbl.push_back(v(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, e(32'h1004, 0, 1, 1, 1, 2)));
`ifdef PC_SEQ_TRAP_EN
      tbl.push_back(v(1, 32'h2000, 0, 1, 32'h80, 0, 0, 1, 32'h101, e(32'h100, 0, 1, 1, 1, 3)));
      tbl.push_back(v(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, e(32'h104, 0, 1, 1, 1, 3)));
      tbl.push_back(v(1, 32'h104, 0, 0, 0, 1, 32'h300, 0, 0, e(32'h300, 0, 1, 1, 0, 1)));
      tbl.push_back(v(1, 32'h300, 0, 0, 0, 0, 0, 1, 32'h500, e(32'h500, 0, 1, 1, 1, 3)));
      tbl.push_back(v(1, 32'h500, 0, 0, 0, 0, 0, 0, 0, e(32'h504, 0, 1, 1, 1, 3)));
`endif
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));
      // PC register model: stall for N cycles holds the PC for exactly N edges
      p   = 32'h3000;
      pat = 7'b0100110;
      for (int i = 0; i < 7; i++) begin
         s  = pat[i];
         nx = s ? p : p + 32'd4;
         apply(v(1, p, s, 0, 0, 0, 0, 0, 0, e(nx, 0, !s, 0, 0, 0)), $sformatf("stall_seq%0d", i));
         p = nx;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
